pia_responder: RTL and testbench

Bus-side responder implementing the Apple-1 6821 PIA register window at 0xD010–0xD013. The CPU bus in the top level drives the block, and it serves that traffic the way WozMon expects. A keyboard byte stream enters through a small FIFO with a valid/ready handshake, and display characters leave through a valid/ready stream. The block sits beside the RAM and ROM on the registered CPU bus, is selected by `uart_cs`-style address decode, and returns read data one clock after a qualified access.

---
 rtl/apple1_pkg.sv | 19 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/pia_responder.sv | 96 +++++++++
 tb/tb_pia_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/apple1_pkg.sv
// Shared Apple-1 bus constants: PIA register offsets, the PIA address window,
// and the keyboard up-case helper.
package apple1_pkg;

  localparam logic [1:0] PIA_KBD   = 2'd0;
  localparam logic [1:0] PIA_KBDCR = 2'd1;
  localparam logic [1:0] PIA_DSP   = 2'd2;
  localparam logic [1:0] PIA_DSPCR = 2'd3;

  // PIA window on the CPU bus; the top level decodes ab against these.
  localparam logic [15:0] PIA_BASE = 16'hD010;
  localparam logic [15:0] PIA_LAST = 16'hD013;

  // Map ASCII 'a'..'z' onto 'A'..'Z'; all other codes pass through.
  function automatic logic [6:0] upcase7(input logic [6:0] c);
    return (c >= 7'h61 && c <= 7'h7A) ? (c - 7'h20) : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head (no read latency).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push into a full FIFO is refused even when a pop
  // happens in the same cycle.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk25) begin
    if (reset_n && push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pia_responder.sv
// Apple-1 6821 PIA register window (KBD/KBDCR/DSP/DSPCR) as WozMon sees it:
// keyboard bytes arrive through a FIFO, display chars leave on a valid/ready
// stream, and reads return registered data one clock after the access.
module pia_responder
  import apple1_pkg::*;
#(
  parameter int KBD_DEPTH = 4,
  parameter int UPCASE    = 1
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [6:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  output logic [6:0] dsp_data,
  output logic       dsp_valid,
  input  logic       dsp_ready
);

  logic       rd, wr, kbd_pop, kbd_push;
  logic       empty, full;
  logic [6:0] head, push_data;
  logic [6:0] kbd_last, kbdcr;
  logic [7:0] dspcr;

  assign rd        = enable && !w_en;
  assign wr        = enable &&  w_en;
  assign kbd_ready = !full;
  assign kbd_push  = kbd_valid && !full;
  assign kbd_pop   = rd && (address == PIA_KBD) && !empty;
  assign push_data = (UPCASE != 0) ? upcase7(kbd_data) : kbd_data;

  sync_fifo #(.WIDTH(7), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk25   (clk25),
    .reset_n (reset_n),
    .push    (kbd_push),
    .pop     (kbd_pop),
    .din     (push_data),
    .head    (head),
    .empty   (empty),
    .full    (full)
  );

  // Read mux into dout plus control-register writes; dout holds between reads.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      dout     <= 8'h00;
      kbd_last <= 7'h00;
      kbdcr    <= 7'h00;
      dspcr    <= 8'h00;
    end else begin
      if (rd) begin
        case (address)
          PIA_KBD: begin
            if (!empty) begin
              dout     <= {1'b1, head};
              kbd_last <= head;
            end else begin
              dout     <= {1'b1, kbd_last};
            end
          end
          PIA_KBDCR: dout <= {!empty, kbdcr};
          PIA_DSP:   dout <= {dsp_valid, dsp_data};
          default:   dout <= dspcr;
        endcase
      end
      if (wr) begin
        case (address)
          PIA_KBDCR: kbdcr <= din[6:0];
          PIA_DSPCR: dspcr <= din;
          default: ;
        endcase
      end
    end
  end

  // Display holding register: a DSP write only lands when nothing is pending,
  // so a write in the handshake cycle is dropped. Data holds after handshake.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      dsp_data  <= 7'h00;
      dsp_valid <= 1'b0;
    end else if (dsp_valid) begin
      if (dsp_ready) dsp_valid <= 1'b0;
    end else if (wr && (address == PIA_DSP)) begin
      dsp_data  <= din[6:0];
      dsp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pia_responder.sv
// Scoreboard bench for pia_responder: read tasks queue the expected dout,
// a monitor pops and compares on the cycle after each read strobe.
module tb_pia_responder;

  logic       clk25 = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [1:0] address;
  logic       w_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic [6:0] kbd_data;
  logic       kbd_valid;
  logic       kbd_ready;
  logic [6:0] dsp_data;
  logic       dsp_valid;
  logic       dsp_ready;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] exp_q [$];
  logic       rd_q1 = 1'b0;

  always #20 clk25 = ~clk25;

  pia_responder #(.KBD_DEPTH(4), .UPCASE(1)) dut (
    .clk25     (clk25),
    .reset_n   (reset_n),
    .enable    (enable),
    .address   (address),
    .w_en      (w_en),
    .din       (din),
    .dout      (dout),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_ready (kbd_ready),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid),
    .dsp_ready (dsp_ready)
  );

  // Remember that a read was strobed so the monitor knows dout is fresh.
  always @(posedge clk25) rd_q1 <= enable && !w_en && reset_n;

  // Monitor: compare dout against the oldest queued expectation.
  always @(negedge clk25) begin
    if (rd_q1) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL dout_unexpected: got %02h, no expectation queued", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          nerr++;
          $display("FAIL dout_read: got %02h expected %02h", dout, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk25); #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    enable = 1'b1; w_en = 1'b0; address = a;
    tick();
    enable = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    enable = 1'b1; w_en = 1'b1; address = a; din = d;
    tick();
    enable = 1'b0; w_en = 1'b0;
  endtask

  task automatic kpush(input logic [6:0] d);
    kbd_valid = 1'b1; kbd_data = d;
    tick();
    kbd_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; address = 2'd0; w_en = 1'b0; din = 8'h00;
    kbd_data = 7'h00; kbd_valid = 1'b0; dsp_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset state
    chk("reset_dout", dout, 8'h00);
    chk("reset_kbd_ready", {7'h0, kbd_ready}, 8'h01);
    chk("reset_dsp_valid", {7'h0, dsp_valid}, 8'h00);
    rd(2'd0, 8'h80);
    rd(2'd1, 8'h00);
    rd(2'd2, 8'h00);
    rd(2'd3, 8'h00);

    // Up-case path and KBD read with/without pop
    kpush(7'h61);
    rd(2'd1, 8'h80);
    rd(2'd0, 8'hC1);
    rd(2'd1, 8'h00);
    rd(2'd0, 8'hC1);

    // Fill to depth, fifth byte refused, order preserved
    kpush(7'h31); kpush(7'h32); kpush(7'h33);
    chk("ready_before_full", {7'h0, kbd_ready}, 8'h01);
    kpush(7'h34);
    chk("ready_when_full", {7'h0, kbd_ready}, 8'h00);
    kpush(7'h35);
    chk("ready_still_full", {7'h0, kbd_ready}, 8'h00);
    rd(2'd0, 8'hB1);
    chk("ready_after_pop", {7'h0, kbd_ready}, 8'h01);
    rd(2'd0, 8'hB2);
    rd(2'd0, 8'hB3);
    rd(2'd0, 8'hB4);
    rd(2'd1, 8'h00);
    rd(2'd0, 8'hB4);

    // Simultaneous push and pop on a partially filled FIFO; 'z' and '{'
    kpush(7'h7A); kpush(7'h7B);
    exp_q.push_back(8'hDA);
    kbd_valid = 1'b1; kbd_data = 7'h63;
    enable = 1'b1; w_en = 1'b0; address = 2'd0;
    tick();
    enable = 1'b0; kbd_valid = 1'b0;
    rd(2'd1, 8'h80);
    rd(2'd0, 8'hFB);
    rd(2'd0, 8'hC3);
    rd(2'd1, 8'h00);

    // Control registers
    wr(2'd3, 8'hA7);
    wr(2'd1, 8'hA7);
    wr(2'd0, 8'h55);
    rd(2'd3, 8'hA7);
    rd(2'd1, 8'h27);
    rd(2'd0, 8'hC3);

    // Display: second write dropped while pending
    dsp_ready = 1'b0;
    wr(2'd2, 8'hC8);
    chk("dsp_valid_set", {7'h0, dsp_valid}, 8'h01);
    wr(2'd2, 8'hC9);
    chk("dsp_data_held", {1'b0, dsp_data}, 8'h48);
    rd(2'd2, 8'hC8);
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    chk("dsp_handshake_clr", {7'h0, dsp_valid}, 8'h00);
    chk("dsp_data_after_hs", {1'b0, dsp_data}, 8'h48);
    rd(2'd2, 8'h48);

    // Write in the handshake cycle is dropped; next write accepted
    wr(2'd2, 8'hC1);
    dsp_ready = 1'b1;
    wr(2'd2, 8'hC2);
    dsp_ready = 1'b0;
    chk("hs_write_drop_valid", {7'h0, dsp_valid}, 8'h00);
    chk("hs_write_drop_data", {1'b0, dsp_data}, 8'h41);
    wr(2'd2, 8'hC3);
    chk("dsp_rewrite_data", {1'b0, dsp_data}, 8'h43);
    rd(2'd2, 8'hC3);

    // Reset mid-operation: FIFO with 3 bytes, display pending
    kpush(7'h44); kpush(7'h45); kpush(7'h46);
    reset_n = 1'b0; dsp_ready = 1'b1;
    tick();
    reset_n = 1'b1; dsp_ready = 1'b0;
    chk("rst_dsp_valid", {7'h0, dsp_valid}, 8'h00);
    chk("rst_dsp_data", {1'b0, dsp_data}, 8'h00);
    chk("rst_kbd_ready", {7'h0, kbd_ready}, 8'h01);
    rd(2'd1, 8'h00);
    rd(2'd0, 8'h80);
    rd(2'd3, 8'h00);

    tick(); tick();
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
